// File: rtl/dshot_tx_if.sv
// Request-side handshake for the DShot transmitter: command payload plus valid/ready.
interface dshot_tx_if;
    logic [10:0] throttle;
    logic        telemetry;
    logic        send_valid;
    logic        send_ready;

    modport master (
        output throttle,
        output telemetry,
        output send_valid,
        input  send_ready
    );

    modport slave (
        input  throttle,
        input  telemetry,
        input  send_valid,
        output send_ready
    );
endinterface

// File: rtl/dshot_tx.sv
// DShot frame transmitter: latches throttle+telemetry, appends the 4-bit CRC and
// serialises 16 bits MSB-first with duty-cycle encoding, followed by a low gap.
module dshot_tx #(
    parameter int BIT_CLKS = 107,
    parameter int T1H_CLKS = 80,
    parameter int T0H_CLKS = 40,
    parameter int GAP_CLKS = 214
) (
    input  logic       clk,
    input  logic       rst_n,
    dshot_tx_if.slave  bus,
    output logic       dshot_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_MAX = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] BIT_PRELAST = CNT_W'(BIT_CLKS - 2);
    localparam logic [CNT_W-1:0] T1H_LAST    = CNT_W'(T1H_CLKS - 1);
    localparam logic [CNT_W-1:0] T0H_LAST    = CNT_W'(T0H_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CLKS - 1);

    generate
        if (!((T0H_CLKS > 0) && (T0H_CLKS < T1H_CLKS) && (T1H_CLKS < BIT_CLKS) && (GAP_CLKS >= 1))) begin : g_bad_params
            $error("dshot_tx: need 0 < T0H_CLKS < T1H_CLKS < BIT_CLKS and GAP_CLKS >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BIT_HIGH,
        BIT_LOW,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [15:0]      frame;

    logic [11:0]      payload;
    logic [3:0]       crc;
    logic [CNT_W-1:0] high_last;
    logic             last_bit_ending;

    assign payload = {bus.throttle, bus.telemetry};
    assign crc     = payload[3:0] ^ payload[7:4] ^ payload[11:8];

    assign high_last = frame[bit_idx] ? T1H_LAST : T0H_LAST;

    // GAP is entered one cycle early so frame_done lines up with the final low cycle of bit 0.
    assign last_bit_ending = (bit_idx == 4'd0) && (cnt == BIT_PRELAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= 4'd0;
            frame          <= 16'h0000;
            dshot_out      <= 1'b0;
            bus.send_ready <= 1'b1;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.send_valid && bus.send_ready) begin
                        frame          <= {payload, crc};
                        bit_idx        <= 4'd15;
                        cnt            <= '0;
                        dshot_out      <= 1'b1;
                        bus.send_ready <= 1'b0;
                        busy           <= 1'b1;
                        state          <= BIT_HIGH;
                    end
                end

                BIT_HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (last_bit_ending) begin
                        cnt        <= '0;
                        dshot_out  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= GAP;
                    end else if (cnt == high_last) begin
                        dshot_out <= 1'b0;
                        state     <= BIT_LOW;
                    end
                end

                BIT_LOW: begin
                    cnt <= cnt + 1'b1;
                    if (last_bit_ending) begin
                        cnt        <= '0;
                        frame_done <= 1'b1;
                        state      <= GAP;
                    end else if (cnt == BIT_LAST) begin
                        bit_idx   <= bit_idx - 4'd1;
                        cnt       <= '0;
                        dshot_out <= 1'b1;
                        state     <= BIT_HIGH;
                    end
                end

                GAP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == GAP_LAST) begin
                        cnt            <= '0;
                        bus.send_ready <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dshot_tx.sv
// Directed self-checking bench for dshot_tx: line waveform, frame contents,
// handshake timing, back-to-back gap and asynchronous reset recovery.
module tb_dshot_tx;

    localparam int BIT_CLKS   = 107;
    localparam int T1H_CLKS   = 80;
    localparam int T0H_CLKS   = 40;
    localparam int GAP_CLKS   = 214;
    localparam int FRAME_CLKS = 16 * BIT_CLKS;
    localparam int READY_AT   = FRAME_CLKS + GAP_CLKS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dshot_out;
    logic busy;
    logic frame_done;

    dshot_tx_if bus ();

    dshot_tx #(
        .BIT_CLKS (BIT_CLKS),
        .T1H_CLKS (T1H_CLKS),
        .T0H_CLKS (T0H_CLKS),
        .GAP_CLKS (GAP_CLKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .dshot_out  (dshot_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Sample i holds the value seen in cycle k+i, where k is the accept edge.
    logic line_s [0:4095];
    logic fd_s   [0:4095];
    logic rdy_s  [0:4095];
    logic busy_s [0:4095];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (bus.send_ready !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) checkOutput("ready_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input logic [10:0] thr, input logic tel, input bit hold, input int n_samples);
        @(negedge clk);
        waitReady();
        bus.throttle   = thr;
        bus.telemetry  = tel;
        bus.send_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= n_samples; i++) begin
            @(negedge clk);
            line_s[i] = dshot_out;
            fd_s[i]   = frame_done;
            rdy_s[i]  = bus.send_ready;
            busy_s[i] = busy;
            if (!hold) begin
                bus.send_valid = 1'b0;
                bus.throttle   = ~thr;
                bus.telemetry  = ~tel;
            end else begin
                if (i % 100 == 0) bus.throttle = 11'(100 + (i / 100) * 3);
                if (i == 3800) bus.send_valid = 1'b0;
            end
        end
        bus.send_valid = 1'b0;
    endtask

    task automatic checkFrame(input int offset, input logic [15:0] expected, input string tag);
        int mism;
        int h;
        int hi_len;
        logic s;
        logic exp_s;
        logic [15:0] dec;
        mism = 0;
        dec = 16'h0000;
        for (int j = 0; j < 16; j++) begin
            h = 0;
            hi_len = expected[15 - j] ? T1H_CLKS : T0H_CLKS;
            for (int p = 0; p < BIT_CLKS; p++) begin
                s = line_s[offset + 1 + j * BIT_CLKS + p];
                exp_s = (p < hi_len);
                if (s !== exp_s) mism++;
                if (s === 1'b1) h++;
            end
            dec[15 - j] = (h > 60);
        end
        checkOutput({tag, "_frame"}, int'(dec), int'(expected));
        checkOutput({tag, "_wave_mismatches"}, mism, 0);
    endtask

    task automatic checkTiming(input string tag);
        int fd_cnt;
        int fd_pos;
        int rdy_pos;
        fd_cnt = 0;
        fd_pos = -1;
        rdy_pos = -1;
        for (int i = 1; i <= READY_AT; i++) begin
            if (fd_s[i] === 1'b1) begin
                fd_cnt++;
                fd_pos = i;
            end
            if (rdy_s[i] === 1'b1 && rdy_pos < 0) rdy_pos = i;
        end
        checkOutput({tag, "_done_count"}, fd_cnt, 1);
        checkOutput({tag, "_done_cycle"}, fd_pos, 1712);
        checkOutput({tag, "_ready_cycle"}, rdy_pos, 1926);
        checkOutput({tag, "_busy_start"}, int'(busy_s[1]), 1);
        checkOutput({tag, "_busy_end"}, int'(busy_s[READY_AT]), 0);
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;

        bus.throttle   = 11'd0;
        bus.telemetry  = 1'b0;
        bus.send_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_line", int'(dshot_out), 0);
        checkOutput("reset_ready", int'(bus.send_ready), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(frame_done), 0);
        rst_n = 1'b1;

        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dshot_out !== 1'b0) cnt_a++;
            if (frame_done !== 1'b0) cnt_b++;
            if (bus.send_ready !== 1'b1 || busy !== 1'b0) cnt_c++;
        end
        checkOutput("idle_line_high", cnt_a, 0);
        checkOutput("idle_done_pulses", cnt_b, 0);
        checkOutput("idle_handshake_bad", cnt_c, 0);

        applyStimulus(11'd1046, 1'b0, 1'b0, READY_AT);
        checkFrame(0, 16'h82C6, "t1046");
        checkTiming("t1046");
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 107; i++) if (line_s[i] === 1'b1) cnt_a++;
        for (int i = 108; i <= 214; i++) if (line_s[i] === 1'b1) cnt_b++;
        checkOutput("t1046_bit15_high", cnt_a, 80);
        checkOutput("t1046_bit14_high", cnt_b, 40);
        checkOutput("t1046_first_cycle", int'(line_s[1]), 1);

        applyStimulus(11'd48, 1'b1, 1'b0, READY_AT);
        checkFrame(0, 16'h0617, "t48");
        checkTiming("t48");

        applyStimulus(11'd0, 1'b0, 1'b0, READY_AT);
        checkFrame(0, 16'h0000, "t0");
        cnt_a = 0;
        for (int i = 1; i <= FRAME_CLKS; i++) if (line_s[i] === 1'b1) cnt_a++;
        checkOutput("t0_total_high", cnt_a, 640);

        applyStimulus(11'd100, 1'b0, 1'b1, 3860);
        checkFrame(0, 16'h0C84, "b2b_first");
        checkFrame(READY_AT, 16'h13A8, "b2b_second");
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 1713; i <= 1926; i++) if (line_s[i] === 1'b0) cnt_a++;
        checkOutput("b2b_gap_low", cnt_a, 214);
        checkOutput("b2b_second_start", int'(line_s[1927]), 1);
        for (int i = 1; i <= 3851; i++) begin
            if (rdy_s[i] === 1'b1) cnt_b++;
            if (busy_s[i] === 1'b0) cnt_c++;
        end
        checkOutput("b2b_ready_pulses", cnt_b, 1);
        checkOutput("b2b_busy_low", cnt_c, 1);
        checkOutput("b2b_ready_final", int'(rdy_s[3852]), 1);

        @(negedge clk);
        waitReady();
        bus.throttle   = 11'd1046;
        bus.telemetry  = 1'b0;
        bus.send_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.send_valid = 1'b0;
        repeat (869) @(negedge clk);
        checkOutput("rst_bit7_high", int'(dshot_out), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_line_async", int'(dshot_out), 0);
        checkOutput("rst_ready", int'(bus.send_ready), 1);
        checkOutput("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(11'd48, 1'b1, 1'b0, READY_AT);
        checkFrame(0, 16'h0617, "post_rst");
        checkTiming("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dshot_tx.md
Name: dshot_tx

Overview:
- DShot frame transmitter; the transmit-side counterpart of the DShot speed receiver.
- Takes an 11-bit throttle command plus telemetry-request bit over a valid/ready handshake.
- Computes the 4-bit CRC, serialises the 16-bit frame MSB-first on a single pin with DShot duty-cycle bit encoding, then enforces a low inter-frame gap.
- Used to drive downstream ESCs and as loopback stimulus for the receiver on the 16 MHz board clock.

Parameters:
- BIT_CLKS, 107: clk cycles per bit period (16 MHz / DShot150).
- T1H_CLKS, 80: high time of a '1' bit in cycles (~75%).
- T0H_CLKS, 40: high time of a '0' bit in cycles (~37.5%).
- GAP_CLKS, 214: minimum low cycles after the last bit before the next frame may start.

Ports:
- clk  in  1  system clock (16 MHz)
- rst_n  in  1  asynchronous active-low reset
- throttle  in  11  throttle/command value, sampled on accept
- telemetry  in  1  telemetry request bit, sampled on accept
- send_valid  in  1  request to transmit throttle/telemetry
- send_ready  out  1  block can accept a frame
- dshot_out  out  1  serial DShot line
- busy  out  1  frame or gap in progress
- frame_done  out  1  one-cycle pulse when the last bit period completes

Behaviour:
- Reset (async, rst_n low): state IDLE, dshot_out=0, send_ready=1, busy=0, frame_done=0; all counters cleared. Reset mid-frame drops dshot_out low on assertion, not at a clock edge. The frame is abandoned and is not resumed.
- Accept occurs at a rising edge with send_valid=1 and send_ready=1.
  - Latch v = {throttle, telemetry} (12 bits).
  - crc = (v ^ (v>>4) ^ (v>>8)) & 4'hF.
  - frame = {v, crc}.
  - send_ready and busy change in the same edge (send_ready=0, busy=1).
- While send_ready=0, send_valid and data inputs are ignored. Input changes after accept do not affect the frame in flight.
- States:
  - IDLE: dshot_out=0, send_ready=1. On accept, go to BIT_HIGH with bit index 15 and cycle counter 0.
  - BIT_HIGH: dshot_out=1 for T1H_CLKS cycles if the current bit is 1, or T0H_CLKS cycles if it is 0; then go to BIT_LOW.
  - BIT_LOW: dshot_out=0 until the bit totals BIT_CLKS cycles.
    - If bit index > 0: decrement the index and go to BIT_HIGH.
    - If bit index = 0: go to GAP and assert frame_done for exactly that one cycle.
  - GAP: dshot_out=0 for GAP_CLKS cycles, then go to IDLE, raising send_ready and dropping busy.
- Timing relative to the accept edge k:
  - First high cycle is k+1, so latency to line is 1 clk.
  - Each bit is exactly BIT_CLKS cycles; the frame occupies 16*BIT_CLKS cycles with no jitter between bits.
  - send_ready is high again exactly 16*BIT_CLKS+GAP_CLKS cycles after k (default 1926).
- Back-to-back operation: a send_valid held high is accepted at the first edge send_ready=1. Frames are then separated by exactly GAP_CLKS low cycles.
- Throttle 0..2047 is transmitted unmodified; there is no clamping, and command values 1..47 are passed through.
- dshot_out is driven from a register (glitch-free).
- Counter width is $clog2(max(BIT_CLKS, GAP_CLKS)+1).
- Parameter legality: 0 < T0H_CLKS < T1H_CLKS < BIT_CLKS and GAP_CLKS ≥ 1. Illegal values fail elaboration.

Test Plan:
- Reset then idle 50 cycles -> dshot_out=0, send_ready=1, busy=0, frame_done never pulses.
- throttle=1046, telemetry=0 -> frame 0x82C6 on line; bit 15 high 80 cycles then low 27; bit 14 high 40 cycles then low 67; frame_done at cycle k+1712; send_ready high at k+1926.
- throttle=48, telemetry=1 -> frame 0x0617 (crc=7), decoded by the DShot receiver as throttle 48 with telemetry set.
- throttle=0, telemetry=0 -> frame 0x0000, 16 pulses each high 40 cycles, period 107.
- send_valid held high with throttle changing every 100 cycles -> each frame carries the value present at its accept edge; exactly 214 low cycles between frames; no accept while busy.
- rst_n pulsed low during bit 7 of a frame -> dshot_out falls immediately; after release, send_ready=1 and a new request transmits a complete, correct frame.
